// File: rtl/chess_input_ctrl.sv
// Purpose : turns debounced button pulses into chess move requests (cursor, source/destination capture, req/ack with game logic).
// Latency : every button or ack takes effect on the clock edge after its pulse; all outputs are registered.
// Backpress: move_req is held until move_ack or the ack timeout; while it is held, button pulses are dropped rather than queued.
//
// Ports:
//   CLK, RESET                  clock and synchronous active-high reset
//   btn_up/down/left/right      one-cycle direction pulses (row+1 / row-1 / col-1 / col+1)
//   btn_center                  one-cycle select/confirm pulse
//   move_ack, move_ok           game-logic verdict on the pending request (ok qualifies ack)
//   cursor_x, cursor_y          current cursor square
//   src_valid, move_from        held source square {row, col}
//   move_to, move_req           destination square {row, col} and request level
//   side                        side to move (0 white, 1 black)
//   err_pulse                   one-cycle flag on an illegal move or an ack timeout
//   state_dbg                   FSM state (00 select source, 01 select destination, 10 request)

module chess_input_ctrl #(
    parameter int START_X     = 4,
    parameter int START_Y     = 0,
    parameter int ACK_TIMEOUT = 4000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    input  logic       move_ack,
    input  logic       move_ok,
    output logic [2:0] cursor_x,
    output logic [2:0] cursor_y,
    output logic       src_valid,
    output logic [5:0] move_from,
    output logic [5:0] move_to,
    output logic       move_req,
    output logic       side,
    output logic       err_pulse,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        SEL_SRC = 2'b00,
        SEL_DST = 2'b01,
        REQ     = 2'b10
    } state_t;

    localparam logic [2:0]  HOME_X   = 3'(START_X);
    localparam logic [2:0]  HOME_Y   = 3'(START_Y);
    localparam logic [13:0] TMO_LAST = 14'(ACK_TIMEOUT - 1);

    state_t      state_q;
    logic [2:0]  cur_x_q, cur_y_q;
    logic [2:0]  cur_x_d, cur_y_d;
    logic        src_valid_q;
    logic [5:0]  from_q, to_q;
    logic        req_q;
    logic        side_q;
    logic        err_q;
    logic [13:0] cnt_q;
    logic        at_src;

    // Cursor after this cycle's direction pulse. Centre outranks every
    // direction, so a centre pulse leaves the cursor where it is; among the
    // directions only the highest-priority one is looked at, and a pulse that
    // would leave the board is a no-op (no fallthrough to a lower button).
    always_comb begin
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (btn_center) begin
            cur_x_d = cur_x_q;
        end else if (btn_up) begin
            if (cur_y_q != 3'd7) cur_y_d = cur_y_q + 3'd1;
        end else if (btn_down) begin
            if (cur_y_q != 3'd0) cur_y_d = cur_y_q - 3'd1;
        end else if (btn_left) begin
            if (cur_x_q != 3'd0) cur_x_d = cur_x_q - 3'd1;
        end else if (btn_right) begin
            if (cur_x_q != 3'd7) cur_x_d = cur_x_q + 3'd1;
        end
    end

    assign at_src = (from_q == {cur_y_q, cur_x_q});

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= SEL_SRC;
            cur_x_q     <= HOME_X;
            cur_y_q     <= HOME_Y;
            src_valid_q <= 1'b0;
            from_q      <= '0;
            to_q        <= '0;
            req_q       <= 1'b0;
            side_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                SEL_SRC: begin
                    cur_x_q <= cur_x_d;
                    cur_y_q <= cur_y_d;
                    if (btn_center) begin
                        from_q      <= {cur_y_q, cur_x_q};
                        src_valid_q <= 1'b1;
                        state_q     <= SEL_DST;
                    end
                end
                SEL_DST: begin
                    cur_x_q <= cur_x_d;
                    cur_y_q <= cur_y_d;
                    if (btn_center) begin
                        if (at_src) begin
                            // Confirming the source square again cancels the selection.
                            src_valid_q <= 1'b0;
                            state_q     <= SEL_SRC;
                        end else begin
                            to_q    <= {cur_y_q, cur_x_q};
                            req_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    // Cursor, buttons and the captured squares are frozen here.
                    if (move_ack) begin
                        req_q       <= 1'b0;
                        src_valid_q <= 1'b0;
                        cur_x_q     <= HOME_X;
                        cur_y_q     <= HOME_Y;
                        side_q      <= side_q ^ move_ok;
                        err_q       <= ~move_ok;
                        state_q     <= SEL_SRC;
                    end else if (cnt_q == TMO_LAST) begin
                        // No verdict in time: treated exactly like an illegal move.
                        req_q       <= 1'b0;
                        src_valid_q <= 1'b0;
                        cur_x_q     <= HOME_X;
                        cur_y_q     <= HOME_Y;
                        err_q       <= 1'b1;
                        state_q     <= SEL_SRC;
                    end else begin
                        cnt_q <= cnt_q + 14'd1;
                    end
                end
                default: begin
                    // Unused encoding 11: fall back to a clean source selection.
                    req_q       <= 1'b0;
                    src_valid_q <= 1'b0;
                    state_q     <= SEL_SRC;
                end
            endcase
        end
    end

    assign cursor_x  = cur_x_q;
    assign cursor_y  = cur_y_q;
    assign src_valid = src_valid_q;
    assign move_from = from_q;
    assign move_to   = to_q;
    assign move_req  = req_q;
    assign side      = side_q;
    assign err_pulse = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_chess_input_ctrl.sv
// Purpose : self-checking bench for chess_input_ctrl against a square/mode-level reference model.
// Latency : model advances once per clock edge; outputs are compared on the falling edge.
// Backpress: none; the bench drives every input each cycle.

module tb_chess_input_ctrl;

    localparam int SX  = 4;
    localparam int SY  = 0;
    localparam int TMO = 40;

    localparam logic [4:0] B_C = 5'b10000;
    localparam logic [4:0] B_U = 5'b01000;
    localparam logic [4:0] B_D = 5'b00100;
    localparam logic [4:0] B_L = 5'b00010;
    localparam logic [4:0] B_R = 5'b00001;
    localparam logic [4:0] B_N = 5'b00000;

    logic       clk = 1'b0;
    logic       rst;
    logic       b_up, b_down, b_left, b_right, b_center;
    logic       ack, ok;
    logic [2:0] cursor_x, cursor_y;
    logic       src_valid;
    logic [5:0] move_from, move_to;
    logic       move_req, side, err_pulse;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    chess_input_ctrl #(
        .START_X     (SX),
        .START_Y     (SY),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .CLK        (clk),
        .RESET      (rst),
        .btn_up     (b_up),
        .btn_down   (b_down),
        .btn_left   (b_left),
        .btn_right  (b_right),
        .btn_center (b_center),
        .move_ack   (ack),
        .move_ok    (ok),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .src_valid  (src_valid),
        .move_from  (move_from),
        .move_to    (move_to),
        .move_req   (move_req),
        .side       (side),
        .err_pulse  (err_pulse),
        .state_dbg  (state_dbg)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: mode 0 = choosing source, 1 = choosing destination, 2 = waiting for verdict.
    int m_mode, m_cx, m_cy, m_sx, m_sy, m_dx, m_dy, m_cnt;
    bit m_sv, m_req, m_side, m_err;

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > 7) ? 7 : v);
    endfunction

    task automatic model_leave_req(input bit legal);
        m_req  = 0;
        m_sv   = 0;
        m_cx   = SX;
        m_cy   = SY;
        m_mode = 0;
        if (legal) m_side = !m_side;
        else       m_err  = 1;
    endtask

    task automatic model_step(input bit r, input logic [4:0] b, input bit a, input bit o);
        if (r) begin
            m_mode = 0; m_cx = SX; m_cy = SY; m_sx = 0; m_sy = 0; m_dx = 0; m_dy = 0;
            m_cnt = 0; m_sv = 0; m_req = 0; m_side = 0; m_err = 0;
            return;
        end
        m_err = 0;
        if (m_mode == 2) begin
            if (a)                   model_leave_req(o);
            else if (m_cnt == TMO-1) model_leave_req(0);
            else                     m_cnt++;
        end else if (b[4]) begin
            if (m_mode == 0) begin
                m_sx = m_cx; m_sy = m_cy; m_sv = 1; m_mode = 1;
            end else if (m_cx == m_sx && m_cy == m_sy) begin
                m_sv = 0; m_mode = 0;
            end else begin
                m_dx = m_cx; m_dy = m_cy; m_req = 1; m_cnt = 0; m_mode = 2;
            end
        end
        else if (b[3]) m_cy = clamp(m_cy + 1);
        else if (b[2]) m_cy = clamp(m_cy - 1);
        else if (b[1]) m_cx = clamp(m_cx - 1);
        else if (b[0]) m_cx = clamp(m_cx + 1);
    endtask

    function automatic logic [23:0] exp_vec();
        return {3'(m_cx), 3'(m_cy), m_sv, 3'(m_sy), 3'(m_sx), 3'(m_dy), 3'(m_dx),
                m_req, m_side, m_err, 2'(m_mode)};
    endfunction

    function automatic logic [23:0] obs_vec();
        return {cursor_x, cursor_y, src_valid, move_from, move_to,
                move_req, side, err_pulse, state_dbg};
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model, compare all outputs.
    task automatic step(input bit r, input logic [4:0] b, input bit a, input bit o, input string tag);
        rst = r;
        {b_center, b_up, b_down, b_left, b_right} = b;
        ack = a;
        ok  = o;
        @(posedge clk);
        model_step(r, b, a, o);
        @(negedge clk);
        check(tag, 32'(obs_vec()), 32'(exp_vec()));
    endtask

    initial begin
        rst = 1'b1; ack = 1'b0; ok = 1'b0;
        {b_center, b_up, b_down, b_left, b_right} = 5'b0;
        @(negedge clk);

        // Reset state
        step(1, B_N, 0, 0, "reset");
        step(1, B_U, 1, 1, "reset_override");
        check("rst_cursor", {cursor_x, cursor_y}, {3'd4, 3'd0});
        check("rst_flags", {src_valid, move_req, side, err_pulse, state_dbg}, 6'b0);

        // Cursor movement and saturation at the board edge
        repeat (3) step(0, B_R, 0, 0, "right");
        repeat (2) step(0, B_U, 0, 0, "up");
        check("cursor_72", {cursor_x, cursor_y}, {3'd7, 3'd2});
        repeat (2) step(0, B_R, 0, 0, "right_sat");
        check("cursor_sat", {cursor_x, cursor_y}, {3'd7, 3'd2});
        step(0, B_D | B_L, 0, 0, "down_beats_left");
        check("prio_down", {cursor_x, cursor_y}, {3'd7, 3'd1});

        // Centre beats up on the same cycle; then cancel by reselecting the source
        step(1, B_N, 0, 0, "reset2");
        step(0, B_C | B_U, 0, 0, "center_up");
        check("sel_src", {src_valid, move_from, cursor_x, cursor_y, state_dbg},
              {1'b1, 6'o04, 3'd4, 3'd0, 2'b01});
        step(0, B_C, 0, 0, "cancel");
        check("cancel", {src_valid, state_dbg, err_pulse, move_req}, {1'b0, 2'b00, 1'b0, 1'b0});

        // Legal move (4,1)->(4,3), acked on the third cycle in REQ
        step(0, B_U, 0, 0, "up");
        step(0, B_C, 0, 0, "src");
        repeat (2) step(0, B_U, 0, 0, "up");
        step(0, B_C, 0, 0, "dst");
        check("req_up", {move_req, move_to, move_from}, {1'b1, 6'o34, 6'o14});
        repeat (2) step(0, B_N, 0, 0, "wait");
        step(0, B_N, 1, 1, "ack_ok");
        check("ack_ok", {move_req, side, cursor_x, cursor_y, state_dbg, err_pulse},
              {1'b0, 1'b1, 3'd4, 3'd0, 2'b00, 1'b0});

        // Timeout with button noise, then an illegal ack; both leave side alone
        for (int k = 0; k < 2; k++) begin
            step(0, B_U, 0, 0, "up");
            step(0, B_C, 0, 0, "src");
            step(0, B_R, 0, 0, "right");
            step(0, B_C, 0, 0, "dst");
            for (int i = 1; i < ((k == 0) ? TMO : 5); i++) begin
                step(0, 5'($urandom), 0, $urandom_range(0, 1), "req_hold");
                check("req_frozen", {move_req, cursor_x, cursor_y, move_to},
                      {1'b1, 3'd5, 3'd1, 6'o15});
            end
            step(0, B_N, k == 1, 0, (k == 0) ? "timeout" : "ack_bad");
            check("err_exit", {err_pulse, move_req, side, state_dbg}, {1'b1, 1'b0, 1'b1, 2'b00});
            step(0, B_N, 0, 0, "err_clear");
            check("err_one_cycle", {31'd0, err_pulse}, 32'd0);
        end

        // Reset while requesting; a late ack must be ignored
        step(0, B_C, 0, 0, "src");
        step(0, B_L, 0, 0, "left");
        step(0, B_C, 0, 0, "dst");
        step(1, B_N, 0, 0, "reset_in_req");
        check("rst_req", {move_req, state_dbg, side, cursor_x, cursor_y},
              {1'b0, 2'b00, 1'b0, 3'd4, 3'd0});
        step(0, B_N, 1, 1, "late_ack");
        check("late_ack", {side, state_dbg, move_req}, {1'b0, 2'b00, 1'b0});

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit       r;
            bit       a;
            logic [4:0] b;
            r = ($urandom_range(0, 299) == 0);
            b = ($urandom_range(0, 2) == 0) ? 5'($urandom) : B_N;
            a = ($urandom_range(0, 19) == 0);
            step(r, b, a, $urandom_range(0, 1), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/chess_input_ctrl.md
Name: chess_input_ctrl

Overview:
Sequences the five debounced push-button pulses (up/down/left/right/centre) into chess move requests. Maintains an 8x8 board cursor, captures source and destination squares, then runs a req/ack handshake with the game-logic block. Sits between the per-button debounce instances and the move validator, in the same slow clock domain as the debouncers.

Parameters:
START_X, 4, cursor column (0..7) after reset and after every completed or aborted move
START_Y, 0, cursor row (0..7) after reset
ACK_TIMEOUT, 4000, cycles in REQ without move_ack before abort (about 0.16 s at 24.4 kHz); 14-bit counter

Ports:
CLK  in  1  system clock, same domain as debouncers
RESET  in  1  synchronous, active-high reset
btn_up  in  1  one-cycle debounced pulse, row+1
btn_down  in  1  one-cycle debounced pulse, row-1
btn_left  in  1  one-cycle debounced pulse, col-1
btn_right  in  1  one-cycle debounced pulse, col+1
btn_center  in  1  one-cycle debounced pulse, select/confirm
move_ack  in  1  game logic has evaluated the current request (one-cycle pulse)
move_ok  in  1  qualifies move_ack: 1 legal, 0 illegal
cursor_x  out  3  current cursor column
cursor_y  out  3  current cursor row
src_valid  out  1  source square is held
move_from  out  6  {src_y, src_x}
move_to  out  6  {dst_y, dst_x}
move_req  out  1  request level, held until ack or timeout
side  out  1  side to move: 0 white, 1 black
err_pulse  out  1  one-cycle pulse on illegal move or timeout
state_dbg  out  2  current FSM state encoding

Behaviour:
- Reset applies on the CLK edge with RESET=1 and overrides all else. Values after reset: cursor=(START_X,START_Y), src_valid=0, move_from=0, move_to=0, move_req=0, side=0, err_pulse=0, timeout counter=0, state=SEL_SRC. RESET in REQ drops move_req on that same edge.
- Arbitration: at most one button is accepted per cycle. Priority is center > up > down > left > right. Lower-priority simultaneous pulses are discarded, not queued.
- Cursor moves saturate at 0 and 7, with no wrap. A move at an edge is a no-op. Cursor updates take effect on the next edge after the pulse (latency 1).
- States (state_dbg): SEL_SRC=00, SEL_DST=01, REQ=10. Encoding 11 is unreachable and recovers to SEL_SRC on the next cycle.
- SEL_SRC:
  - Direction pulses move the cursor.
  - center: move_from <= cursor, src_valid <= 1, go to SEL_DST.
- SEL_DST:
  - Direction pulses move the cursor.
  - center with cursor == move_from: cancel, src_valid <= 0, go to SEL_SRC. No error is raised.
  - center otherwise: move_to <= cursor, move_req <= 1, counter <= 0, go to REQ.
- REQ:
  - All button pulses are ignored, and the cursor is frozen.
  - move_from and move_to are stable while move_req=1.
  - The counter increments each cycle.
- REQ exit on move_ack (checked before timeout when both occur on the same cycle):
  - Common actions: move_req <= 0, src_valid <= 0, cursor <= (START_X,START_Y), go to SEL_SRC.
  - move_ok=1: side toggles.
  - move_ok=0: err_pulse=1 for exactly one cycle; side is unchanged.
- Timeout: if the counter reaches ACK_TIMEOUT-1 with no ack, the block takes the same exit as an illegal move. err_pulse=1, move_req=0, state=SEL_SRC.
- move_ack outside REQ is ignored.
- err_pulse is registered and high for exactly one cycle per event.

Test Plan:
- Reset then right x3, up x2 -> cursor=(7,2). Then right x2 -> cursor stays (7,2) (saturation).
- btn_center+btn_up on the same cycle from (4,0) in SEL_SRC -> src_valid=1, move_from=6'o04, cursor unchanged, state_dbg=01.
- Select (4,1) as source, move up x2, centre -> move_req=1, move_to=6'o34. Ack with move_ok=1 three cycles later -> move_req=0 next edge, side=1, cursor=(4,0), state_dbg=00.
- Select source, then centre on the same square -> src_valid=0, state_dbg=00, err_pulse stays 0, move_req stays 0.
- Enter REQ, pulse buttons, and hold move_ack low for ACK_TIMEOUT cycles:
  - Buttons have no effect while in REQ.
  - On timeout: err_pulse one-cycle, move_req=0, side unchanged.
  - Repeat with move_ack and move_ok=0 -> same response.
- Assert RESET while in REQ -> next edge: move_req=0, state_dbg=00, side=0, cursor=(START_X,START_Y). A later move_ack is ignored.
